// File: rtl/msrv32_pc_gen_p.sv
// msrv32_pc_gen_p: program counter generator with stall-tolerant redirect capture.
// Revision 1.0
`default_nettype none

module msrv32_pc_gen_p #(
   parameter int                 XLEN      = 32,
   parameter logic [XLEN-1:0]    BOOT_ADDR = '0,
   parameter int                 IALIGN    = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            ahb_ready_in,
   input  logic            branch_taken_in,
   input  logic [1:0]      pc_src_in,
   input  logic [XLEN-1:0] epc_in,
   input  logic [XLEN-1:0] trap_address_in,
   input  logic [XLEN-1:1] iaddr_in,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_4_out,
   output logic [XLEN-1:0] pc_mux_out,
   output logic [XLEN-1:0] iaddr_out,
   output logic            misaligned_instr_logic_out,
   output logic            redirect_pending_out
);

   localparam logic [1:0] SRC_BOOT = 2'b00;
   localparam logic [1:0] SRC_EPC  = 2'b01;
   localparam logic [1:0] SRC_TRAP = 2'b10;
   localparam logic [1:0] SRC_SEQ  = 2'b11;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] redirect_addr;
   logic [XLEN-1:0] pend_addr;
   logic [XLEN-1:0] next_pc;
   logic            pend_valid;
   logic            redirect_req;
   logic            misaligned;

   assign target        = {iaddr_in, 1'b0};
   assign pc_plus_4_out = pc + {{(XLEN-3){1'b0}}, 3'd4};

   generate
      if (IALIGN == 32) begin : g_align32
         assign misaligned = branch_taken_in & (pc_src_in == SRC_SEQ) & target[1];
      end else begin : g_align16
         assign misaligned = 1'b0;
      end
   endgenerate

   // Redirect request and address, ignoring any held pending entry.
   always_comb begin
      redirect_req  = 1'b1;
      redirect_addr = BOOT_ADDR;
      case (pc_src_in)
         SRC_BOOT: redirect_addr = BOOT_ADDR;
         SRC_TRAP: redirect_addr = trap_address_in;
         SRC_EPC:  redirect_addr = epc_in;
         default: begin
            redirect_req  = branch_taken_in & ~misaligned;
            redirect_addr = target;
         end
      endcase
   end

   // Boot/trap/epc outrank the pending entry; the pending entry outranks a new branch.
   always_comb begin
      next_pc = pc_plus_4_out;
      if (pc_src_in != SRC_SEQ)
         next_pc = redirect_addr;
      else if (pend_valid)
         next_pc = pend_addr;
      else if (redirect_req)
         next_pc = target;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pc         <= BOOT_ADDR;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
      end else if (!misaligned) begin
         if (ahb_ready_in) begin
            pc         <= next_pc;
            pend_valid <= 1'b0;
         end else if (redirect_req) begin
            pend_valid <= 1'b1;
            pend_addr  <= redirect_addr;
         end
      end
   end

   assign pc_out                     = pc;
   assign pc_mux_out                 = next_pc;
   assign iaddr_out                  = (ahb_ready_in && !misaligned) ? next_pc : pc;
   assign misaligned_instr_logic_out = misaligned;
   assign redirect_pending_out       = pend_valid;

endmodule

`default_nettype wire

// File: tb/tb_msrv32_pc_gen_p.sv
// Scoreboard bench for msrv32_pc_gen_p: directed vectors, expectations queued, monitor compares.
`default_nettype none

module tb_msrv32_pc_gen_p;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        ahb_ready_in = 1'b1;
   logic        branch_taken_in = 1'b0;
   logic [1:0]  pc_src_in = 2'b11;
   logic [31:0] epc_in = '0;
   logic [31:0] trap_address_in = '0;
   logic [31:1] iaddr_in = '0;
   logic [31:0] pc_out, pc_plus_4_out, pc_mux_out, iaddr_out;
   logic        misaligned_instr_logic_out, redirect_pending_out;

   msrv32_pc_gen_p #(.XLEN(32), .BOOT_ADDR(32'h0), .IALIGN(32)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .ahb_ready_in(ahb_ready_in),
      .branch_taken_in(branch_taken_in), .pc_src_in(pc_src_in),
      .epc_in(epc_in), .trap_address_in(trap_address_in), .iaddr_in(iaddr_in),
      .pc_out(pc_out), .pc_plus_4_out(pc_plus_4_out), .pc_mux_out(pc_mux_out),
      .iaddr_out(iaddr_out), .misaligned_instr_logic_out(misaligned_instr_logic_out),
      .redirect_pending_out(redirect_pending_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] p4;
      logic [31:0] mux;
      logic [31:0] iaddr;
      logic        pend;
      logic        mis;
   } exp_t;

   exp_t q[$];
   int   compared = 0;
   int   mismatched = 0;
   bit   stim_done = 0;

   task automatic chk32(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
      end
   endtask

   // Drive inputs just after the falling edge and queue the values expected
   // shortly before the following rising edge.
   task automatic step(input string n, input logic rst, input logic rdy, input logic [1:0] src,
                       input logic tk, input logic [31:0] tgt, input logic [31:0] epc,
                       input logic [31:0] trap, input logic [31:0] e_pc, input logic e_pend,
                       input logic [31:0] e_mux, input logic e_mis, input logic [31:0] e_iaddr);
      exp_t e;
      @(negedge clk_in);
      #1;
      rst_in = rst; ahb_ready_in = rdy; pc_src_in = src; branch_taken_in = tk;
      iaddr_in = tgt[31:1]; epc_in = epc; trap_address_in = trap;
      e.name = n; e.pc = e_pc; e.p4 = e_pc + 32'd4; e.mux = e_mux; e.iaddr = e_iaddr;
      e.pend = e_pend; e.mis = e_mis;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_in);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk32(e.name, "pc_out", pc_out, e.pc);
            chk32(e.name, "pc_plus_4", pc_plus_4_out, e.p4);
            chk32(e.name, "pc_mux", pc_mux_out, e.mux);
            chk32(e.name, "iaddr_out", iaddr_out, e.iaddr);
            chk32(e.name, "pending", {31'b0, redirect_pending_out}, {31'b0, e.pend});
            chk32(e.name, "misaligned", {31'b0, misaligned_instr_logic_out}, {31'b0, e.mis});
         end
      end
   end

   initial begin : stimulus
      //    name       rst rdy src   tk tgt         epc           trap          pc            pend mux           mis iaddr
      step("rst",      0,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h0,        0,   32'h4,        0,  32'h4);
      step("seq0",     1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h0,        0,   32'h4,        0,  32'h4);
      step("seq1",     1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h4,        0,   32'h8,        0,  32'h8);
      step("seq2",     1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h8,        0,   32'hC,        0,  32'hC);
      step("br80",     1,  1,  2'b11,1, 32'h80,     32'h0,        32'h0,        32'hC,        0,   32'h80,       0,  32'h80);
      step("mis82",    1,  1,  2'b11,1, 32'h82,     32'h0,        32'h0,        32'h80,       0,   32'h84,       1,  32'h80);
      step("stallbr",  1,  0,  2'b11,1, 32'h100,    32'h0,        32'h0,        32'h80,       0,   32'h100,      0,  32'h80);
      step("stallhld", 1,  0,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h80,       1,   32'h100,      0,  32'h80);
      step("issue",    1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h80,       1,   32'h100,      0,  32'h100);
      step("stall200", 1,  0,  2'b11,1, 32'h200,    32'h0,        32'h0,        32'h100,      0,   32'h200,      0,  32'h100);
      step("trapovr",  1,  1,  2'b10,0, 32'h0,      32'h0,        32'h11223344, 32'h100,      1,   32'h11223344, 0,  32'h11223344);
      step("epcwrap",  1,  1,  2'b01,0, 32'h0,      32'hFFFFFFFC, 32'h0,        32'h11223344, 0,   32'hFFFFFFFC, 0,  32'hFFFFFFFC);
      step("wrap",     1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'hFFFFFFFC, 0,   32'h0,        0,  32'h0);
      step("epc",      1,  1,  2'b01,0, 32'h0,      32'hAABBCCDC, 32'h0,        32'h0,        0,   32'hAABBCCDC, 0,  32'hAABBCCDC);
      step("stall400", 1,  0,  2'b11,1, 32'h400,    32'h0,        32'h0,        32'hAABBCCDC, 0,   32'h400,      0,  32'hAABBCCDC);
      step("ovrwr500", 1,  0,  2'b01,0, 32'h0,      32'h500,      32'h0,        32'hAABBCCDC, 1,   32'h500,      0,  32'hAABBCCDC);
      step("hold500",  1,  0,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'hAABBCCDC, 1,   32'h500,      0,  32'hAABBCCDC);
      step("bootovr",  1,  1,  2'b00,0, 32'h0,      32'h0,        32'h0,        32'hAABBCCDC, 1,   32'h0,        0,  32'h0);
      step("afterbt",  1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h0,        0,   32'h4,        0,  32'h4);
      step("stall600", 1,  0,  2'b11,1, 32'h600,    32'h0,        32'h0,        32'h4,        0,   32'h600,      0,  32'h4);
      step("hold600",  1,  0,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h4,        1,   32'h600,      0,  32'h4);
      step("asyncrst", 0,  0,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h0,        0,   32'h4,        0,  32'h0);
      step("relrst",   1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h0,        0,   32'h4,        0,  32'h4);
      step("postrst",  1,  1,  2'b11,0, 32'h0,      32'h0,        32'h0,        32'h4,        0,   32'h8,        0,  32'h8);
      stim_done = 1;
   end

   initial begin : finisher
      int budget;
      wait (stim_done);
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(negedge clk_in);
         budget++;
      end
      @(negedge clk_in);
      if (q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain pending_expectations=%0d required=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
